// File: rtl/register_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package rf_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_CLEAR,
        RF_DONE
    } rf_clr_state_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Issue/writeback-facing bundle of the register file. The master side is the pipeline
// (decode, issue, writeback). The slave side is the register file itself.
interface register_file_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN_DEF,
    parameter int NREGS  = RF_NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
);

    logic [NWRITE-1:0]      we;
    logic [NWRITE*AW-1:0]   waddr;
    logic [NWRITE*XLEN-1:0] wdata;
    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*XLEN-1:0]  rdata;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic [NREAD-1:0]       rs_pending;
    logic                   clear_req;
    logic                   clear_busy;
    logic                   clear_done;

    modport master (
        output we, waddr, wdata, raddr, issue_valid, issue_rd, clear_req,
        input  rdata, rs_pending, clear_busy, clear_done
    );

    modport slave (
        input  we, waddr, wdata, raddr, issue_valid, issue_rd, clear_req,
        output rdata, rs_pending, clear_busy, clear_done
    );

endinterface

// File: rtl/register_file_mp_write_arb.sv
// Folds the NWRITE write ports into one enable bit and one data word per register.
// Register 0 is filtered out. When two ports hit the same address, the higher port wins.
module rf_write_arb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   en,
    input  logic [NWRITE-1:0]      we,
    input  logic [NWRITE*AW-1:0]   waddr,
    input  logic [NWRITE*XLEN-1:0] wdata,
    output logic [NREGS-1:0]       reg_we,
    output logic [XLEN-1:0]        reg_wdata [NREGS]
);

    logic [AW-1:0] addr;

    // NOTE: every output gets a default before the loop, so no path leaves a value held (no latch).
    always_comb begin
        addr   = '0;
        reg_we = '0;
        for (int r = 0; r < NREGS; r++) begin
            reg_wdata[r] = '0;
        end
        // Ascending port order lets the last (highest) matching port overwrite earlier ones.
        for (int k = 0; k < NWRITE; k++) begin
            addr = waddr[k*AW +: AW];
            if (en && we[k] && (addr != '0)) begin
                reg_we[addr]    = 1'b1;
                reg_wdata[addr] = wdata[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file. It has a hardwired-zero r0, a per-register pending
// scoreboard and a sequential clear engine. Optional macro RF_BYPASS_EN forwards same-cycle writes to the read ports.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN_DEF,
    parameter int NREGS  = RF_NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    register_file_mp_if.slave  bus
);

    rf_clr_state_t  state;
    logic [AW-1:0]  clr_idx;
    logic           busy_q;
    logic           done_q;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;

    logic [NREGS-1:0] reg_we;
    logic [XLEN-1:0]  reg_wdata [NREGS];

    logic clearing;
    logic issue_ok;

    assign clearing = (state == RF_CLEAR);
    assign issue_ok = bus.issue_valid && !clearing && (bus.issue_rd != '0);

    rf_write_arb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_write_arb (
        .en        (state == RF_IDLE),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .wdata     (bus.wdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RF_IDLE;
            clr_idx <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.clear_req) begin
                        state   <= RF_CLEAR;
                        clr_idx <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state  <= RF_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RF_DONE: begin
                    state  <= RF_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= RF_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is built from flops with an async reset, because the pipeline relies on all-zero state after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (clearing && (clr_idx == AW'(r))) begin
                    regs[r] <= '0;
                end else if (reg_we[r]) begin
                    regs[r] <= reg_wdata[r];
                end
            end
        end
    end

    // A same-cycle issue beats a write clear: the newly issued producer is still outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (clearing && (clr_idx == AW'(r))) begin
                    pend[r] <= 1'b0;
                end else if (issue_ok && (bus.issue_rd == AW'(r))) begin
                    pend[r] <= 1'b1;
                end else if (reg_we[r]) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    logic [AW-1:0] ra;

    always_comb begin
        ra             = '0;
        bus.rdata      = '0;
        bus.rs_pending = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = bus.raddr[i*AW +: AW];
            bus.rdata[i*XLEN +: XLEN] = regs[ra];
            bus.rs_pending[i]         = pend[ra];
`ifdef RF_BYPASS_EN
            if (!busy_q && reg_we[ra]) begin
                bus.rdata[i*XLEN +: XLEN] = reg_wdata[ra];
                bus.rs_pending[i]         = issue_ok && (bus.issue_rd == ra);
            end
`endif
        end
    end

    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp. Read expectations come from a bench-side
// model and go through a FIFO scoreboard. Expectations follow RF_BYPASS_EN when it is defined.
module tb_register_file_mp;
    import rf_pkg::*;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_mp_if #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)
    ) bus ();

    register_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] model_regs [NREGS];
    logic            model_pend [NREGS];
    logic [XLEN-1:0] exp_q [$];

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [XLEN-1:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected <empty scoreboard>", tag, got);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic model_zero();
        for (int r = 0; r < NREGS; r++) begin
            model_regs[r] = '0;
            model_pend[r] = 1'b0;
        end
    endtask

    // Reads one register combinationally on one port. Call this away from the clock edge.
    task automatic read_port(input int port, input int addr);
        bus.raddr[port*AW +: AW] = AW'(addr);
        exp_q.push_back(model_regs[addr]);
        #1;
        sb_check($sformatf("rd%0d r%0d", port, addr), bus.rdata[port*XLEN +: XLEN]);
        check($sformatf("pend%0d r%0d", port, addr), XLEN'(bus.rs_pending[port]), XLEN'(model_pend[addr]));
    endtask

    task automatic read_all();
        for (int r = 0; r < NREGS; r++) begin
            read_port(r % 2, r);
        end
    endtask

    // Presents one cycle of writes/issue starting from a negedge, then applies the same update to the model.
    task automatic drive_cycle(input logic w0, input int a0, input logic [XLEN-1:0] d0,
                               input logic w1, input int a1, input logic [XLEN-1:0] d1,
                               input logic iv, input int ird);
        bus.we                   = {w1, w0};
        bus.waddr[0*AW +: AW]    = AW'(a0);
        bus.waddr[1*AW +: AW]    = AW'(a1);
        bus.wdata[0*XLEN +: XLEN] = d0;
        bus.wdata[1*XLEN +: XLEN] = d1;
        bus.issue_valid          = iv;
        bus.issue_rd             = AW'(ird);
        @(negedge clk);
        bus.we          = '0;
        bus.issue_valid = 1'b0;
        if (w0 && a0 != 0) begin model_regs[a0] = d0; model_pend[a0] = 1'b0; end
        if (w1 && a1 != 0) begin model_regs[a1] = d1; model_pend[a1] = 1'b0; end
        if (iv && ird != 0) model_pend[ird] = 1'b1;
    endtask

    task automatic fill_all();
        for (int r = 1; r < NREGS; r += 2) begin
            drive_cycle(1'b1, r, 32'hA5A5_0000 | XLEN'(r),
                        (r + 1 < NREGS), (r + 1) % NREGS, 32'h5A5A_0000 | XLEN'(r + 1),
                        1'b0, 0);
        end
    endtask

    int busy_cnt;
    int done_cnt;
    int done_edge;

    initial begin
        reset           = 1'b0;
        bus.we          = '0;
        bus.waddr       = '0;
        bus.wdata       = '0;
        bus.raddr       = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.clear_req   = 1'b0;
        model_zero();

        #12;
        check("rst busy", XLEN'(bus.clear_busy), 0);
        check("rst done", XLEN'(bus.clear_done), 0);
        @(negedge clk);
        reset = 1'b1;
        read_all();

        // r0 is hardwired to zero
        drive_cycle(1'b1, 0, 32'hDEAD_BEEF, 1'b0, 0, '0, 1'b0, 0);
        read_port(0, 0);
        read_port(1, 0);

        // Same-address collision: port 1 wins
        drive_cycle(1'b1, 5, 32'h1111_1111, 1'b1, 5, 32'h2222_2222, 1'b0, 0);
        check("collision r5", model_regs[5], 32'h2222_2222);
        read_port(0, 5);
        read_port(1, 5);

        // Independent writes on both ports, including the top register
        drive_cycle(1'b1, 1, 32'h0000_0001, 1'b1, 31, 32'hFFFF_FFFF, 1'b0, 0);
        drive_cycle(1'b1, 2, 32'h1234_5678, 1'b1, 3, 32'h0123_4567, 1'b0, 0);
        read_port(0, 31);
        read_port(1, 1);
        read_port(0, 2);
        read_port(1, 3);

        // Scoreboard: set, clear by write, set wins over same-cycle clear, r0 never pending
        drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 7);
        read_port(0, 7);
        drive_cycle(1'b0, 0, '0, 1'b1, 7, 32'h0000_0777, 1'b0, 0);
        read_port(1, 7);
        drive_cycle(1'b1, 7, 32'h0000_0778, 1'b0, 0, '0, 1'b1, 7);
        check("sb set wins", XLEN'(model_pend[7]), 1);
        read_port(0, 7);
        drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 0);
        read_port(1, 0);

        // Same-cycle write/read of r3 while r3 is pending
        drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 3);
        bus.raddr[0*AW +: AW]     = AW'(3);
        bus.we                    = 2'b01;
        bus.waddr[0*AW +: AW]     = AW'(3);
        bus.wdata[0*XLEN +: XLEN] = 32'hCAFE_F00D;
        #1;
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'hCAFE_F00D);
        sb_check("bypass r3 data", bus.rdata[0*XLEN +: XLEN]);
        check("bypass r3 pend", XLEN'(bus.rs_pending[0]), 0);
`else
        exp_q.push_back(model_regs[3]);
        sb_check("no-bypass r3 data", bus.rdata[0*XLEN +: XLEN]);
        check("no-bypass r3 pend", XLEN'(bus.rs_pending[0]), 1);
`endif
        @(negedge clk);
        bus.we = '0;
        model_regs[3] = 32'hCAFE_F00D;
        model_pend[3] = 1'b0;
        read_port(0, 3);

        // Clear engine: full sweep, with a write and an issue attempted mid-clear
        fill_all();
        drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 12);
        read_port(0, 30);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = 0;
        bus.clear_req = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            bus.clear_req = 1'b0;
            if (bus.clear_busy) busy_cnt++;
            if (bus.clear_done) begin done_cnt++; done_edge = e; end
            if (e == 1)  check("clr busy at edge1", XLEN'(bus.clear_busy), 1);
            if (e == 33) check("clr busy at edge33", XLEN'(bus.clear_busy), 0);
            if (e == 10) begin
                bus.we                    = 2'b01;
                bus.waddr[0*AW +: AW]     = AW'(9);
                bus.wdata[0*XLEN +: XLEN] = 32'h5555_5555;
                bus.issue_valid           = 1'b1;
                bus.issue_rd              = AW'(9);
            end
            if (e == 11) begin
                bus.we          = '0;
                bus.issue_valid = 1'b0;
            end
        end
        check("clr busy cycles", XLEN'(busy_cnt), 32);
        check("clr done edge", XLEN'(done_edge), 33);
        check("clr done count", XLEN'(done_cnt), 1);
        model_zero();
        @(negedge clk);
        read_all();

        // Reset while the engine sits at idx=10
        fill_all();
        drive_cycle(1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 25);
        bus.clear_req = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            bus.clear_req = 1'b0;
        end
        check("midclr busy before rst", XLEN'(bus.clear_busy), 1);
        reset = 1'b0;
        #1;
        check("midclr busy in rst", XLEN'(bus.clear_busy), 0);
        check("midclr done in rst", XLEN'(bus.clear_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.clear_busy) busy_cnt++;
            if (bus.clear_done) done_cnt++;
        end
        check("midclr no busy after", XLEN'(busy_cnt), 0);
        check("midclr no done", XLEN'(done_cnt), 0);
        model_zero();
        @(negedge clk);
        read_all();

        check("scoreboard drained", XLEN'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file, the successor to the core's single-write, two-read register file. Adds:
- configurable width, depth and port counts
- hardwired-zero register 0
- per-register pending scoreboard for the issue stage
- sequential clear engine that zeroes the array without a global reset

Sits between decode/issue (reads, pending checks) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of combinational read ports (1..4)
NWRITE, 2, number of write ports (1..2); higher index wins on same-address collision
AW, $clog2(NREGS), address width (derived, localparam)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
we  in  NWRITE  per-port write enable
waddr  in  NWRITE*AW  write addresses, port k at [k*AW +: AW]
wdata  in  NWRITE*XLEN  write data, port k at [k*XLEN +: XLEN]
raddr  in  NREAD*AW  read addresses
rdata  out  NREAD*XLEN  read data
issue_valid  in  1  mark issue_rd pending this cycle
issue_rd  in  AW  destination being issued
rs_pending  out  NREAD  pending bit of each raddr
clear_req  in  1  start sequential clear (level sampled in IDLE)
clear_busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse after last register cleared

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers 0 and all pending bits 0
  - FSM to IDLE; clear_busy=0, clear_done=0
- Register 0:
  - writes ignored; always reads 0; pending bit always 0
  - issue_valid with issue_rd=0 has no effect
- Writes:
  - registered on the rising edge when we[k]=1 and waddr!=0 and FSM is IDLE
  - two ports to the same address: port NWRITE-1 data wins
- Reads:
  - combinational from the array
  - without bypass (see Optional Feature), same-cycle writes become visible the next cycle
- Scoreboard:
  - issue_valid sets pending[issue_rd] at the edge
  - any accepted write clears pending[waddr]
  - same-cycle set and clear on the same address: set wins, because the new producer is outstanding
  - rs_pending[i] = pending[raddr_i], combinational
- Clear FSM:
  - IDLE:
    - clear_req=1 -> CLEAR with idx=0
    - clear_busy=0
  - CLEAR:
    - each cycle registers[idx]<=0 and pending[idx]<=0, then idx++
    - clear_busy=1
    - all writes and issue_valid are dropped
    - clear_req is ignored
    - at idx=NREGS-1 -> DONE
  - DONE:
    - clear_done=1 for exactly one cycle, then -> IDLE
    - writes are still blocked during DONE
  - latency: clear_req sampled high -> clear_done high after NREGS+1 edges
- Reset mid-clear: immediate return to IDLE, all state zero, no clear_done.
- idx width is AW; no wrap, because the transition to DONE happens on the last index.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined:
  - a read address matching an accepted same-cycle write returns that write data (highest matching port) instead of array contents
  - rs_pending for that address reads 0 unless issue_valid targets it in the same cycle
  - bypass is disabled while clear_busy=1
- Undefined:
  - reads reflect array state only
  - rs_pending reflects registered pending bits only

Decomposition:
- Package rf_pkg holds:
  - default XLEN/NREGS localparams
  - clear FSM state enum rf_clr_state_t {RF_IDLE, RF_CLEAR, RF_DONE}
- One natural sub-module, rf_write_arb: resolves NWRITE enables/addresses into a per-register write-enable vector and data select, including the port-priority rule.
- Top holds the array, scoreboard, FSM and read muxes.

Test Plan:
- Reset and register 0: after reset, read all 32 regs -> 0. Write 0xDEADBEEF to reg 0 -> reads 0.
- Dual-write collision: port0 writes r5=0x11111111 and port1 writes r5=0x22222222 in the same cycle -> next cycle r5=0x22222222.
- Scoreboard: issue r7 -> rs_pending=1. Write r7 -> pending 0 next cycle. Issue r7 and write r7 in the same cycle -> pending stays 1.
- Clear engine: fill r1..r31 with nonzero values, pulse clear_req.
  - clear_busy high for 32 cycles, clear_done pulses at edge 33, all regs 0
  - a write attempted mid-clear is dropped
- Reset mid-clear: assert reset at idx=10 -> clear_busy=0 immediately, no clear_done, all regs 0.
- RF_BYPASS_EN: write r3=0xCAFEF00D while reading r3 in the same cycle.
  - defined: rdata=0xCAFEF00D
  - undefined: rdata=old value, and 0xCAFEF00D the next cycle
